// File: rtl/slave_buf_pkg.sv
// rtl/slave_buf_pkg.sv - shared state enum and default sizing for slave_buf
package slave_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/slave_buf.sv
// rtl/slave_buf.sv - valid/ready FIFO slave buffer; SLAVE_BUF_STATS_EN adds rx_cnt
module slave_buf
    import slave_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data,
    output logic                     ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
`ifdef SLAVE_BUF_STATS_EN
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               rx_cnt
`else
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    buf_state_t        state;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     level_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              remove;

    // ready and out_valid are registers, so the handshakes only depend on state
    assign accept = valid && ready;
    assign remove = out_valid && out_ready;

    // head word is forced to zero whenever nothing is stored
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // occupancy after this edge; accept+remove together leaves it unchanged
    always_comb begin
        level_nxt = level;
        case ({accept, remove})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // control FSM: pointers, occupancy, state and registered handshake outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= EMPTY;
            level     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ready     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            level     <= level_nxt;
            ready     <= (level_nxt != LW'(DEPTH));
            out_valid <= (level_nxt != '0);
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (remove) rd_ptr <= rd_ptr + PW'(1);
            case (state)
                EMPTY: if (accept) state <= PART;
                PART: begin
                    if (accept && !remove && level == LW'(DEPTH - 1))
                        state <= FULL;
                    else if (remove && !accept && level == LW'(1))
                        state <= EMPTY;
                end
                FULL: if (remove) state <= PART;
                default: state <= EMPTY;
            endcase
        end
    end

    // storage array; contents are don't-care until written
    always_ff @(posedge sys_clk) begin
        if (accept) mem[wr_ptr] <= data;
    end

`ifdef SLAVE_BUF_STATS_EN
    // saturating count of accepted words
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_cnt <= 8'd0;
        end else if (accept && rx_cnt != 8'hFF) begin
            rx_cnt <= rx_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_slave_buf.sv
// tb/tb_slave_buf.sv - scoreboard bench for slave_buf
module tb_slave_buf;
    import slave_buf_pkg::*;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic [LW-1:0]     level;
`ifdef SLAVE_BUF_STATS_EN
    logic [7:0]        rx_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int m_level  = 0;
    int m_rx     = 0;
    logic [DATA_W-1:0] sb [$];

    slave_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .valid     (valid),
        .data      (data),
        .ready     (ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef SLAVE_BUF_STATS_EN
        .level     (level),
        .rx_cnt    (rx_cnt)
`else
        .level     (level)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_state(input int lv);
        if (lv == 0) return 2'(EMPTY);
        if (lv == DEPTH) return 2'(FULL);
        return 2'(PART);
    endfunction

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] head;
        head = (sb.size() != 0) ? sb[0] : '0;
        chk({tag, ".level"}, 32'(level), 32'(m_level));
        chk({tag, ".ready"}, 32'(ready), 32'(m_level != DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_level != 0));
        chk({tag, ".out_data"}, 32'(out_data), 32'(head));
        chk({tag, ".state"}, 32'(dut.state), 32'(exp_state(m_level)));
`ifdef SLAVE_BUF_STATS_EN
        chk({tag, ".rx_cnt"}, 32'(rx_cnt), 32'(m_rx));
`endif
    endtask

    // one clock cycle: drive at negedge, update model at the edge, check after it
    task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic do_check);
        logic acc, rem;
        @(negedge sys_clk);
        valid = v;
        data = d;
        out_ready = ordy;
        acc = v && (m_level != DEPTH);
        rem = ordy && (m_level != 0);
        @(posedge sys_clk);
        #1;
        if (rem) void'(sb.pop_front());
        if (acc) begin
            sb.push_back(d);
            if (m_rx < 255) m_rx++;
        end
        m_level = m_level + (acc ? 1 : 0) - (rem ? 1 : 0);
        if (do_check) check_all(tag);
    endtask

    initial begin
        // reset state
        #12;
        check_all("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // three accepts, nothing drained
        step("acc0", 1'b1, 3'b111, 1'b0, 1'b1);
        step("acc1", 1'b1, 3'b101, 1'b0, 1'b1);
        step("acc2", 1'b1, 3'b110, 1'b0, 1'b1);

        // fill to full, then keep offering a fifth word
        step("fill", 1'b1, 3'b011, 1'b0, 1'b1);
        step("full_hold0", 1'b1, 3'b001, 1'b0, 1'b1);
        step("full_hold1", 1'b1, 3'b001, 1'b0, 1'b1);

        // one remove from full while valid still held
        step("full_rm", 1'b1, 3'b001, 1'b1, 1'b1);
        step("after_rm", 1'b0, 3'b000, 1'b0, 1'b1);

        // drain everything, then poke out_ready while empty
        for (int i = 0; i < 5; i++) step("drain", 1'b0, 3'b000, 1'b1, 1'b1);
        step("empty_ordy", 1'b0, 3'b000, 1'b1, 1'b1);

        // streaming across pointer wrap
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 3'(i * 3 + 1), 1'b1, 1'b1);
        step("stream_end", 1'b0, 3'b000, 1'b1, 1'b1);

        // load two words then reset asynchronously mid-cycle
        step("pre_rst0", 1'b1, 3'b010, 1'b0, 1'b1);
        step("pre_rst1", 1'b1, 3'b100, 1'b0, 1'b1);
        @(negedge sys_clk);
        valid = 1'b0;
        out_ready = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        sb.delete();
        m_level = 0;
        m_rx = 0;
        check_all("async_rst");
        #4;
        sys_rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 3'b000, 1'b1, 1'b1);
        step("post_rst_new", 1'b1, 3'b001, 1'b0, 1'b1);
        step("post_rst_rd", 1'b0, 3'b000, 1'b1, 1'b1);

`ifdef SLAVE_BUF_STATS_EN
        // saturation of the accept counter
        for (int i = 0; i < 300; i++) step("sat", 1'b1, 3'(i), 1'b1, 1'b0);
        chk("rx_cnt_sat", 32'(rx_cnt), 32'd255);
        check_all("sat_end");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/slave_buf.md
SLAVE_BUF -- requirements
Module: slave_buf

Interface
REQ-001 The parameter DATA_W SHALL default to 3 and sets the payload width.
REQ-002 The parameter DEPTH SHALL default to 4 and sets the number of buffer entries; it SHALL be a power of two and at least 2.
REQ-003 The port sys_clk SHALL be a 1-bit input: the single clock, rising edge active.
REQ-004 The port sys_rst_n SHALL be a 1-bit input: reset, asynchronous and active-low.
REQ-005 The port valid SHALL be a 1-bit input: the upstream word on data is valid.
REQ-006 The port data SHALL be a DATA_W-bit input: the upstream payload.
REQ-007 The port ready SHALL be a 1-bit output: the buffer can accept a word this cycle.
REQ-008 The port out_valid SHALL be a 1-bit output: the head entry on out_data is valid.
REQ-009 The port out_data SHALL be a DATA_W-bit output: the head-of-buffer payload.
REQ-010 The port out_ready SHALL be a 1-bit input: the downstream consumer takes the head word.
REQ-011 The port level SHALL be a $clog2(DEPTH)+1-bit output: the current occupancy, 0..DEPTH.

Function
REQ-012 An upstream word SHALL be accepted on a rising sys_clk edge exactly when valid && ready.
REQ-013 A head word SHALL be removed on a rising sys_clk edge exactly when out_valid && out_ready.
REQ-014 ready SHALL equal (level != DEPTH) and SHALL be driven from registers only, with no combinational path from valid, data or out_ready.
REQ-015 out_valid SHALL equal (level != 0), and out_data SHALL be the oldest stored word; out_data SHALL be 0 when level == 0.
REQ-016 The latency from acceptance to out_valid SHALL be 1 cycle; there is no combinational bypass when empty.
REQ-017 A simultaneous accept and remove SHALL leave level unchanged and preserve FIFO order; this is legal at any level from 1 to DEPTH-1.
REQ-018 When full, valid SHALL be ignored (ready=0); a remove in that cycle SHALL make ready=1 on the following cycle.
REQ-019 When empty, out_ready SHALL be ignored and level SHALL NOT underflow.
REQ-020 The write and read pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH without special handling.
REQ-021 The state machine SHALL have three states: EMPTY, PART and FULL, with level as the source of truth.
REQ-022 EMPTY SHALL go to PART on an accept.
REQ-023 PART SHALL go to FULL on an accept-only when level==DEPTH-1.
REQ-024 PART SHALL go to EMPTY on a remove-only when level==1.
REQ-025 FULL SHALL go to PART on a remove.
REQ-026 All other conditions SHALL hold the current state.
REQ-027 The state SHALL always be consistent with level; a mismatch is a design error for the bench to flag.

Reset
REQ-028 Asserting sys_rst_n low SHALL immediately force state=EMPTY, level=0, both pointers=0, ready=1, out_valid=0 and out_data=0.
REQ-029 Reset asserted mid-transfer SHALL discard all stored words; no word accepted before reset SHALL appear after it.
REQ-030 Storage array contents SHALL NOT need reset.

Configuration
REQ-031 With SLAVE_BUF_STATS_EN defined, the block SHALL add an 8-bit output rx_cnt that counts accepted words.
REQ-032 rx_cnt SHALL saturate at 255, reset to 0, and increment on the same edge as the accept.
REQ-033 With SLAVE_BUF_STATS_EN not defined, rx_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 A shared package slave_buf_pkg SHALL hold the state enum typedef (EMPTY, PART, FULL) and the default DATA_W and DEPTH constants.
REQ-035 There SHALL be a single flat module with no sub-module; the storage is an inferred register array.

Verification
REQ-036 Reset, then 3 accepts of 3'b111, 3'b101, 3'b110 with out_ready=0 -> level=3, out_data=3'b111, state PART, ready=1.
REQ-037 Fill 4 words with out_ready=0, then hold valid=1 -> level=4, state FULL, ready=0; a 5th word is not stored.
REQ-038 From full, out_ready=1 for 1 cycle -> 1 word removed, level=3, ready=1 next cycle; order is preserved.
REQ-039 Continuous valid=1 and out_ready=1 from empty for 20 cycles -> after the first cycle, level stays at 1 and output order equals input order across pointer wrap.
REQ-040 Load 2 words, then pulse sys_rst_n low asynchronously mid-cycle -> out_valid=0 and level=0 at once; those words never reappear.
REQ-041 With SLAVE_BUF_STATS_EN defined, 300 accepts -> rx_cnt=255.
